// File: rtl/uart_bus_bridge_pkg.sv
// Shared command/response codes, state encodings and helpers for the UART debug bridge.
package uart_bus_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } parser_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  // Down-counters run from cyc-1 to 0, so a terminal count of zero spans cyc cycles.
  function automatic logic [15:0] baud_reload(input int unsigned cyc);
    return 16'(cyc - 1);
  endfunction

endpackage

// File: rtl/bridge_uart_rx.sv
// 8N1 UART receiver: synchronizer, start-bit validation, mid-bit sampling, framing check.
//   state    | meaning
//   RX_IDLE  | line high, waiting for a falling edge
//   RX_START | half-bit wait to confirm the start bit
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit
//   RX_WAIT  | framing error seen, waiting for the line to return high
module bridge_uart_rx
  import uart_bus_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  localparam logic [15:0] BIT_RELOAD  = baud_reload(BAUD_DIV);
  localparam logic [15:0] HALF_RELOAD = baud_reload(BAUD_DIV / 2);

  logic [1:0]  sync;
  logic        rx_s;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == 16'd0) begin
            if (!rx_s) begin
              cnt     <= BIT_RELOAD;
              bit_idx <= '0;
              state   <= RX_DATA;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == 16'd0) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= BIT_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == 16'd0) begin
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
              state    <= RX_IDLE;
            end else begin
              state <= RX_WAIT;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_WAIT: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug bridge: parses W/R command frames, issues one bus cycle, replies on UART_TX.
//   state   | meaning
//   ST_IDLE | waiting for a command byte
//   ST_ADDR | collecting 4 address bytes, MSB first
//   ST_DATA | collecting 4 write-data bytes, MSB first
//   ST_BUS  | single-cycle rd or wr strobe
//   ST_RESP | sending the response byte(s)
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam logic [15:0] BIT_RELOAD     = baud_reload(BAUD_DIV);
  localparam logic [31:0] TIMEOUT_RELOAD = 32'(TIMEOUT_CYC - 1);

  logic          rx_valid;
  logic [7:0]    rx_byte;

  parser_state_t state;
  logic          op_wr;
  logic [1:0]    byte_cnt;
  logic [31:0]   timer;
  logic [31:0]   resp_shift;
  logic [1:0]    resp_left;

  logic          tx_load;
  logic [7:0]    tx_byte;
  logic          tx_done;
  logic          tx_active;
  logic [15:0]   tx_cnt;
  logic [3:0]    tx_idx;
  logic [7:0]    tx_data;

  bridge_uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (UART_RX),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  // Response frames are launched combinationally so the start bit follows the BUS cycle directly
  // and consecutive read bytes go out back to back.
  always_comb begin
    tx_load = 1'b0;
    tx_byte = RSP_ERR;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_byte != CMD_WR && rx_byte != CMD_RD) tx_load = 1'b1;
      end
      ST_BUS: begin
        tx_load = 1'b1;
        tx_byte = op_wr ? RSP_OK : rdata[31:24];
      end
      ST_RESP: begin
        if (tx_done && resp_left != 2'd0) begin
          tx_load = 1'b1;
          tx_byte = resp_shift[31:24];
        end
      end
      default: ;
    endcase
  end

  assign tx_done = tx_active && (tx_cnt == 16'd0) && (tx_idx == 4'd9);

  // tx_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      UART_TX   <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_data   <= '0;
    end else if (tx_load) begin
      UART_TX   <= 1'b0;
      tx_active <= 1'b1;
      tx_cnt    <= BIT_RELOAD;
      tx_idx    <= '0;
      tx_data   <= tx_byte;
    end else if (tx_active) begin
      if (tx_cnt == 16'd0) begin
        if (tx_idx == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          tx_idx  <= tx_idx + 4'd1;
          tx_cnt  <= BIT_RELOAD;
          UART_TX <= (tx_idx == 4'd8) ? 1'b1 : tx_data[tx_idx[2:0]];
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op_wr      <= 1'b0;
      byte_cnt   <= '0;
      timer      <= '0;
      resp_shift <= '0;
      resp_left  <= '0;
      addr       <= '0;
      wdata      <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rd <= 1'b0;
      wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            busy     <= 1'b1;
            timer    <= TIMEOUT_RELOAD;
            byte_cnt <= '0;
            if (rx_byte == CMD_WR) begin
              op_wr <= 1'b1;
              state <= ST_ADDR;
            end else if (rx_byte == CMD_RD) begin
              op_wr <= 1'b0;
              state <= ST_ADDR;
            end else begin
              resp_left <= '0;
              state     <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            addr     <= {addr[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            timer    <= TIMEOUT_RELOAD;
            if (byte_cnt == 2'd3) begin
              if (op_wr) begin
                state <= ST_DATA;
              end else begin
                rd    <= 1'b1;
                state <= ST_BUS;
              end
            end
          end else if (timer == 32'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            wdata    <= {wdata[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            timer    <= TIMEOUT_RELOAD;
            if (byte_cnt == 2'd3) begin
              wr    <= 1'b1;
              state <= ST_BUS;
            end
          end else if (timer == 32'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        ST_BUS: begin
          // Top byte of rdata already went to the serializer this cycle.
          if (!op_wr) resp_shift <= {rdata[23:0], 8'h00};
          resp_left <= op_wr ? 2'd0 : 2'd3;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (tx_done) begin
            if (resp_left != 2'd0) begin
              resp_shift <= resp_shift << 8;
              resp_left  <= resp_left - 2'd1;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: UART driver, UART_TX decoder and bus-strobe recorder.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        UART_RX;
  logic        UART_TX;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] rd_val;

  int          tests_run = 0;
  int          fails = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        overlap = 1'b0;
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  assign rdata = rd ? rd_val : 32'h0;

  uart_bus_bridge #(
    .BAUD_DIV    (16),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .UART_TX (UART_TX),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (rd) begin
      rd_count = rd_count + 1;
      rd_addr  = addr;
    end
    if (wr) begin
      wr_count = wr_count + 1;
      wr_addr  = addr;
      wr_data  = wdata;
    end
    if (rd && wr) overlap = 1'b1;
  end

  // UART_TX decoder, 16 clocks per bit, sampling near mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (UART_TX === 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = UART_TX;
        end
        repeat (16) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    UART_RX = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (16) @(negedge clk);
    end
    UART_RX = stop;
    repeat (16) @(negedge clk);
    UART_RX = 1'b1;
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    logic [71:0] t;
    t = v;
    for (int i = 0; i < n; i++) begin
      send_byte(t[71:64], 1'b1);
      t = t << 8;
    end
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 3000 && tx_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && busy !== 1'b0; c++) @(negedge clk);
  endtask

  task automatic clear_obs();
    rd_count = 0;
    wr_count = 0;
    tx_q.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    UART_RX = 1'b1;
    rd_val  = 32'h0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({UART_TX, rd, wr, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctrl: got tx/rd/wr/busy=%b expected 1000", {UART_TX, rd, wr, busy});
    end
    tests_run++;
    if ({addr, wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", addr, wdata);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    clear_obs();
    send_bytes(72'h57_40_00_00_0C_00_00_00_A5, 9);
    wait_bytes(1);
    wait_idle();
    tests_run++;
    if (wr_count !== 1 || rd_count !== 0) begin
      fails++;
      $display("FAIL write_pulses: got wr=%0d rd=%0d expected 1/0", wr_count, rd_count);
    end
    tests_run++;
    if ({wr_addr, wr_data} !== {32'h4000000C, 32'h000000A5}) begin
      fails++;
      $display("FAIL write_bus: got addr=%h wdata=%h expected 4000000c/000000a5", wr_addr, wr_data);
    end
    tests_run++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      fails++;
      $display("FAIL write_resp: got %0d bytes first=%h expected 1 byte 4b", tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'hxx);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL write_busy: got busy=%b expected 0", busy);
    end
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] got;
    clear_obs();
    rd_val = d;
    send_bytes({8'h52, a, 32'h0}, 5);
    wait_bytes(4);
    wait_idle();
    got = '0;
    for (int i = 0; i < tx_q.size(); i++) got = {got[23:0], tx_q[i]};
    tests_run++;
    if (rd_count !== 1 || wr_count !== 0 || rd_addr !== a) begin
      fails++;
      $display("FAIL %s_bus: got rd=%0d wr=%0d addr=%h expected 1/0/%h", name, rd_count, wr_count, rd_addr, a);
    end
    tests_run++;
    if (tx_q.size() !== 4 || got !== d) begin
      fails++;
      $display("FAIL %s_resp: got %0d bytes value=%h expected 4 bytes %h", name, tx_q.size(), got, d);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy: got busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_read();
    do_read("read", 32'h40000010, 32'h12345678);
  endtask

  task automatic test_bad_cmd();
    clear_obs();
    send_byte(8'h41, 1'b1);
    wait_bytes(1);
    wait_idle();
    tests_run++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h3F || rd_count !== 0 || wr_count !== 0) begin
      fails++;
      $display("FAIL bad_cmd: got %0d bytes first=%h rd=%0d wr=%0d expected 1 byte 3f, no strobes",
               tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'hxx, rd_count, wr_count);
    end
    do_read("after_bad", 32'h00000020, 32'hCAFEF00D);
  endtask

  task automatic test_timeout();
    clear_obs();
    send_bytes({8'h57, 8'h40, 8'h00, 48'h0}, 3);
    repeat (2500) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tx_q.size() !== 0) begin
      fails++;
      $display("FAIL timeout_abort: got busy=%b bytes=%0d expected 0/0", busy, tx_q.size());
    end
    do_read("after_timeout", 32'h00000004, 32'h0A0B0C0D);
    tests_run++;
    if (wr_count !== 0) begin
      fails++;
      $display("FAIL timeout_no_wr: got wr=%0d expected 0", wr_count);
    end
  endtask

  task automatic test_framing();
    clear_obs();
    @(negedge clk);
    UART_RX = 1'b0;
    repeat (4) @(negedge clk);
    UART_RX = 1'b1;
    repeat (200) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tx_q.size() !== 0) begin
      fails++;
      $display("FAIL glitch: got busy=%b bytes=%0d expected 0/0", busy, tx_q.size());
    end
    send_byte(8'h57, 1'b0);
    repeat (40) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL framing_drop: got busy=%b expected 0", busy);
    end
    do_read("after_framing", 32'h00000100, 32'h89ABCDEF);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_bytes({8'h57, 32'h4000000C, 8'h00, 24'h0}, 6);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({UART_TX, busy, wr, rd} !== 4'b1000 || {addr, wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid: got tx/busy/wr/rd=%b addr=%h wdata=%h expected 1000/0/0",
               {UART_TX, busy, wr, rd}, addr, wdata);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    tests_run++;
    if (wr_count !== 0 || tx_q.size() !== 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: got wr=%0d bytes=%0d expected 0/0", wr_count, tx_q.size());
    end
    clear_obs();
    send_bytes(72'h57_00_00_00_08_00_00_00_5A, 9);
    wait_bytes(1);
    wait_idle();
    tests_run++;
    if (wr_count !== 1 || wr_addr !== 32'h8 || wr_data !== 32'h5A || tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      fails++;
      $display("FAIL reset_mid_next: got wr=%0d addr=%h wdata=%h bytes=%0d expected 1/8/5a/1x4b",
               wr_count, wr_addr, wr_data, tx_q.size());
    end
  endtask

  task automatic test_strobe_exclusive();
    tests_run++;
    if (overlap !== 1'b0) begin
      fails++;
      $display("FAIL strobe_overlap: got overlap=%b expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_timeout();
    test_framing();
    test_reset_mid();
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
